// File: rtl/writeback_unit_pkg.sv
// Shared defaults and FSM state encoding for the writeback stage.
package writeback_unit_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wbState_t;

endpackage

// File: rtl/wb_load_timer.sv
// Wait counter for outstanding loads; expire flags the last allowed waiting cycle.
module wb_load_timer #(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  logic [TW-1:0] count;

  assign expire = (count == TW'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: retires ALU results and loads into the register-file write port.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic              in_wen,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              pending_valid,
  output logic [REG_AW-1:0] pending_reg,
  output logic              load_timeout,
  output logic [15:0]       retire_count
);

  wbState_t    state;
  logic        capWen;
  logic [15:0] retireCount;
  logic        accept;
  logic        timerClear;
  logic        timerEn;
  logic        timerExpire;

  assign in_ready     = (state == ST_IDLE);
  assign accept       = in_valid & in_ready;
  assign retire_count = retireCount;
  assign timerClear   = accept & in_is_load;
  assign timerEn      = (state == ST_WAIT_LOAD) & ~mem_rvalid;

  wb_load_timer #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) uTimer (
    .clk   (clk),
    .reset (reset),
    .clear (timerClear),
    .enable(timerEn),
    .expire(timerExpire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      capWen        <= 1'b0;
      RegWrite      <= 1'b0;
      WriteReg      <= '0;
      WriteData     <= '0;
      pending_valid <= 1'b0;
      pending_reg   <= '0;
      load_timeout  <= 1'b0;
      retireCount   <= '0;
    end else begin
      RegWrite <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!in_is_load) begin
              RegWrite    <= in_wen;
              WriteReg    <= in_dest;
              WriteData   <= in_result;
              retireCount <= retireCount + 16'd1;
            end else begin
              pending_reg   <= in_dest;
              capWen        <= in_wen;
              pending_valid <= 1'b1;
              state         <= ST_WAIT_LOAD;
            end
          end
        end
        ST_WAIT_LOAD: begin
          // Returning data takes priority over the timeout in the final waiting cycle.
          if (mem_rvalid) begin
            RegWrite      <= capWen;
            WriteReg      <= pending_reg;
            WriteData     <= mem_rdata;
            retireCount   <= retireCount + 16'd1;
            pending_valid <= 1'b0;
            pending_reg   <= '0;
            state         <= ST_IDLE;
          end else if (timerExpire) begin
            load_timeout  <= 1'b1;
            pending_valid <= 1'b0;
            pending_reg   <= '0;
            state         <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
